pos_ring_node_ctrl: RTL and testbench

- Per-node traffic controller for the position input ring.
- Each ring packet carries a destination global cell ID (gcid) and a position payload.
- Incoming packets whose gcid matches a local target cell are ejected to the local position cache; all other packets are forwarded.
- Locally generated packets are buffered and merged into the outgoing ring slot, with a starvation-bounded priority scheme.

---
 rtl/MD_pkg.sv | 18 +
 rtl/pos_ring_inject_fifo.sv | 51 +++++
 rtl/pos_ring_node_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pos_ring_node_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared types for the position input ring: cell ID width, ring packet
// layout and the forward/inject arbitration states.
package MD_pkg;

    localparam int GLOBAL_CELL_ID_WIDTH = 3;
    localparam int POS_PAYLOAD_WIDTH    = 96;

    typedef struct packed {
        logic [3*GLOBAL_CELL_ID_WIDTH-1:0] gcid;
        logic [POS_PAYLOAD_WIDTH-1:0]      data;
    } pos_ring_pkt_t;

    typedef enum logic {
        RING_PRI = 1'b0,
        INJ_PRI  = 1'b1
    } pos_ring_arb_state_t;

endpackage

// File: rtl/pos_ring_inject_fifo.sv
// Synchronous FIFO buffering locally generated ring packets. The full flag
// is registered so the inject ready seen upstream comes straight from a flop.
module pos_ring_inject_fifo
    import MD_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type pkt_t = pos_ring_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  pkt_t wr_pkt,
    input  logic rd_en,
    output pkt_t rd_pkt,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    pkt_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   cnt_nxt;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_pkt  = mem[rd_ptr[AW-1:0]];
    assign cnt_nxt = (wr_ptr - rd_ptr) + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            full <= (cnt_nxt == (AW+1)'(DEPTH));
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_pkt;
    end

endmodule

// File: rtl/pos_ring_node_ctrl.sv
// Position-ring node: ejects packets addressed to local cells and merges local
// injects into the forward slot. Define POS_RING_STATS_EN for traffic counters.
module pos_ring_node_ctrl
    import MD_pkg::*;
#(
    parameter int NUM_TARGETS = 1,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_X [NUM_TARGETS] = '{3'h1},
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Y [NUM_TARGETS] = '{3'h1},
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Z [NUM_TARGETS] = '{3'h1},
    parameter int PAYLOAD_WIDTH = 96,
    parameter int FIFO_DEPTH    = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_ring_valid,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_ring_gcid,
    input  logic [PAYLOAD_WIDTH-1:0]          i_ring_data,
    output logic                              o_ring_ready,
    output logic                              o_ring_valid,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_ring_gcid,
    output logic [PAYLOAD_WIDTH-1:0]          o_ring_data,
    input  logic                              i_ring_ready,
    input  logic                              i_inj_valid,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_inj_gcid,
    input  logic [PAYLOAD_WIDTH-1:0]          i_inj_data,
    output logic                              o_inj_ready,
    output logic                              o_local_valid,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_local_gcid,
    output logic [PAYLOAD_WIDTH-1:0]          o_local_data,
    input  logic                              i_local_ready
`ifdef POS_RING_STATS_EN
    ,
    output logic [31:0]                       o_fwd_cnt,
    output logic [31:0]                       o_ej_cnt,
    output logic [31:0]                       o_inj_cnt,
    output logic [31:0]                       o_starve_cnt
`endif
);

    localparam int GCID_W = 3*GLOBAL_CELL_ID_WIDTH;
    localparam int SW     = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [GCID_W-1:0]        gcid;
        logic [PAYLOAD_WIDTH-1:0] data;
    } node_pkt_t;

    pos_ring_arb_state_t state, state_nxt;
    logic [SW-1:0]       starve_cnt, starve_nxt;
    node_pkt_t           inj_head, fwd_sel;
    logic                fifo_empty, fifo_full;
    logic                hit, ej_free, fwd_free;
    logic                ring_load, inj_load, ej_load;
    logic                fwd_vld_p1, ej_vld_p1;
    node_pkt_t           fwd_pkt_p1, ej_pkt_p1;

    pos_ring_inject_fifo #(
        .DEPTH (FIFO_DEPTH),
        .pkt_t (node_pkt_t)
    ) u_inj_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (i_inj_valid),
        .wr_pkt ({i_inj_gcid, i_inj_data}),
        .rd_en  (inj_load),
        .rd_pkt (inj_head),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (i_ring_gcid == {GCELL_Z[k], GCELL_Y[k], GCELL_X[k]}) hit = 1'b1;
        end
    end

    assign ej_free     = !ej_vld_p1 || i_local_ready;
    assign fwd_free    = !fwd_vld_p1 || i_ring_ready;
    assign ej_load     = i_ring_valid && hit && ej_free;
    assign o_inj_ready = !fifo_full;

    // Hit packets only see the eject slot; non-hit packets only the forward slot.
    assign o_ring_ready = hit ? ej_free : (state == RING_PRI) && fwd_free;
    assign ring_load    = i_ring_valid && !hit && o_ring_ready;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        inj_load   = 1'b0;
        case (state)
            RING_PRI: begin
                if (ring_load) begin
                    if (!fifo_empty) begin
                        starve_nxt = starve_cnt + 1'b1;
                        if (starve_nxt == SW'(STARVE_LIMIT)) state_nxt = INJ_PRI;
                    end
                end else if (fwd_free && !fifo_empty) begin
                    inj_load   = 1'b1;
                    starve_nxt = '0;
                end
            end
            INJ_PRI: begin
                if (fifo_empty) begin
                    state_nxt  = RING_PRI;
                    starve_nxt = '0;
                end else if (fwd_free) begin
                    inj_load   = 1'b1;
                    state_nxt  = RING_PRI;
                    starve_nxt = '0;
                end
            end
            default: begin
                state_nxt  = RING_PRI;
                starve_nxt = '0;
            end
        endcase
    end

    assign fwd_sel = ring_load ? node_pkt_t'({i_ring_gcid, i_ring_data}) : inj_head;

    // Stage p1: forward and eject output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RING_PRI;
            starve_cnt <= '0;
            fwd_vld_p1 <= 1'b0;
            fwd_pkt_p1 <= '0;
            ej_vld_p1  <= 1'b0;
            ej_pkt_p1  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (ring_load || inj_load) begin
                fwd_vld_p1 <= 1'b1;
                fwd_pkt_p1 <= fwd_sel;
            end else if (i_ring_ready) begin
                fwd_vld_p1 <= 1'b0;
            end
            if (ej_load) begin
                ej_vld_p1 <= 1'b1;
                ej_pkt_p1 <= {i_ring_gcid, i_ring_data};
            end else if (i_local_ready) begin
                ej_vld_p1 <= 1'b0;
            end
        end
    end

    assign o_ring_valid  = fwd_vld_p1;
    assign o_ring_gcid   = fwd_pkt_p1.gcid;
    assign o_ring_data   = fwd_pkt_p1.data;
    assign o_local_valid = ej_vld_p1;
    assign o_local_gcid  = ej_pkt_p1.gcid;
    assign o_local_data  = ej_pkt_p1.data;

`ifdef POS_RING_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fwd_cnt    <= '0;
            o_ej_cnt     <= '0;
            o_inj_cnt    <= '0;
            o_starve_cnt <= '0;
        end else begin
            o_fwd_cnt    <= sat_inc(o_fwd_cnt, fwd_vld_p1 && i_ring_ready);
            o_ej_cnt     <= sat_inc(o_ej_cnt, ej_vld_p1 && i_local_ready);
            o_inj_cnt    <= sat_inc(o_inj_cnt, inj_load);
            o_starve_cnt <= sat_inc(o_starve_cnt, (state == RING_PRI) && (state_nxt == INJ_PRI));
        end
    end
`endif

endmodule

// File: tb/tb_pos_ring_node_ctrl.sv
// Scoreboard bench for pos_ring_node_ctrl: directed stimulus pushes expected
// packets; a negedge monitor pops and compares every output transfer.
module tb_pos_ring_node_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ring_valid, o_ring_ready, o_ring_valid, i_ring_ready;
    logic [8:0]  i_ring_gcid, o_ring_gcid, i_inj_gcid, o_local_gcid;
    logic [95:0] i_ring_data, o_ring_data, i_inj_data, o_local_data;
    logic        i_inj_valid, o_inj_ready, o_local_valid, i_local_ready;

    logic [104:0] exp_ring_q[$];
    logic [104:0] exp_loc_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pos_ring_node_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_ring_valid  (i_ring_valid),
        .i_ring_gcid   (i_ring_gcid),
        .i_ring_data   (i_ring_data),
        .o_ring_ready  (o_ring_ready),
        .o_ring_valid  (o_ring_valid),
        .o_ring_gcid   (o_ring_gcid),
        .o_ring_data   (o_ring_data),
        .i_ring_ready  (i_ring_ready),
        .i_inj_valid   (i_inj_valid),
        .i_inj_gcid    (i_inj_gcid),
        .i_inj_data    (i_inj_data),
        .o_inj_ready   (o_inj_ready),
        .o_local_valid (o_local_valid),
        .o_local_gcid  (o_local_gcid),
        .o_local_data  (o_local_data),
        .i_local_ready (i_local_ready)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ring(input logic [8:0] g, input logic [95:0] d);
        i_ring_valid = 1'b1;
        i_ring_gcid  = g;
        i_ring_data  = d;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_ring_valid && i_ring_ready) begin
                if (exp_ring_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ring_unexpected: got %0h expected none", {o_ring_gcid, o_ring_data});
                end else begin
                    chk("ring_out", {o_ring_gcid, o_ring_data}, exp_ring_q.pop_front());
                end
            end
            if (o_local_valid && i_local_ready) begin
                if (exp_loc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL local_unexpected: got %0h expected none", {o_local_gcid, o_local_data});
                end else begin
                    chk("local_out", {o_local_gcid, o_local_data}, exp_loc_q.pop_front());
                end
            end
        end
    end

    initial begin
        int k, cyc, stall_cnt, stall_at;
        rst = 1'b1;
        i_ring_valid = 1'b0; i_ring_gcid = '0; i_ring_data = '0;
        i_inj_valid  = 1'b0; i_inj_gcid  = '0; i_inj_data  = '0;
        i_ring_ready = 1'b1; i_local_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ring_valid", o_ring_valid, 0);
        chk("rst_local_valid", o_local_valid, 0);
        chk("rst_ring_gcid", o_ring_gcid, 0);
        chk("rst_local_data", o_local_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        chk("rst_inj_ready", o_inj_ready, 1);

        // Hit packet ejects with 1-cycle latency, nothing forwarded
        exp_loc_q.push_back({9'b001001001, 96'hA1});
        drive_ring(9'b001001001, 96'hA1);
        @(negedge clk);
        chk("hit_ready", o_ring_ready, 1);
        tick();
        i_ring_valid = 1'b0;
        @(negedge clk);
        chk("hit_local_valid", o_local_valid, 1);
        chk("hit_no_fwd", o_ring_valid, 0);
        tick();

        // Two non-hit packets forwarded in order
        exp_ring_q.push_back({9'b000000001, 96'hB1});
        exp_ring_q.push_back({9'b001000001, 96'hB2});
        drive_ring(9'b000000001, 96'hB1);
        @(negedge clk);
        chk("fwd_a_ready", o_ring_ready, 1);
        tick();
        drive_ring(9'b001000001, 96'hB2);
        @(negedge clk);
        chk("fwd_latency", o_ring_valid, 1);
        chk("fwd_no_local", o_local_valid, 0);
        chk("fwd_b_ready", o_ring_ready, 1);
        tick();
        i_ring_valid = 1'b0;
        @(negedge clk);
        chk("fwd_b_valid", o_ring_valid, 1);
        tick(); tick();

        // Starvation: inject to a local cell is forwarded after 4 losses
        for (int j = 0; j < 5; j++) exp_ring_q.push_back({9'o002, 96'h300 + 96'(j)});
        exp_ring_q.push_back({9'b001001001, 96'hC0});
        for (int j = 5; j < 10; j++) exp_ring_q.push_back({9'o002, 96'h300 + 96'(j)});
        k = 0; cyc = 0; stall_cnt = 0; stall_at = -1;
        i_inj_valid = 1'b1; i_inj_gcid = 9'b001001001; i_inj_data = 96'hC0;
        while (k < 10 && cyc < 60) begin
            drive_ring(9'o002, 96'h300 + 96'(k));
            @(negedge clk);
            if (o_ring_ready) k++;
            else begin
                stall_cnt++;
                stall_at = cyc;
            end
            tick();
            i_inj_valid = 1'b0;
            cyc++;
        end
        i_ring_valid = 1'b0;
        chk("starve_all_sent", k, 10);
        chk("starve_stall_cnt", stall_cnt, 1);
        chk("starve_stall_slot", stall_at, 5);
        repeat (3) tick();

        // Fill the inject FIFO behind a held output, then drain in order
        i_ring_ready = 1'b0;
        exp_ring_q.push_back({9'o004, 96'hD0});
        drive_ring(9'o004, 96'hD0);
        @(negedge clk);
        chk("fill_x_ready", o_ring_ready, 1);
        tick();
        i_ring_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_ring_q.push_back({9'o005, 96'hE0 + 96'(j)});
            i_inj_valid = 1'b1; i_inj_gcid = 9'o005; i_inj_data = 96'hE0 + 96'(j);
            @(negedge clk);
            chk("fill_inj_ready", o_inj_ready, 1);
            tick();
        end
        i_inj_valid = 1'b0;
        @(negedge clk);
        chk("fill_full", o_inj_ready, 0);
        chk("fill_held_data", o_ring_data, 96'hD0);
        tick();
        i_ring_ready = 1'b1;
        repeat (11) tick();
        chk("drain_inj_ready", o_inj_ready, 1);

        // Stalled downstream: hit ejects, non-hit waits
        i_ring_ready = 1'b0;
        exp_ring_q.push_back({9'o006, 96'hF0});
        exp_loc_q.push_back({9'b001001001, 96'hF1});
        exp_ring_q.push_back({9'o007, 96'hF2});
        drive_ring(9'o006, 96'hF0);
        tick();
        drive_ring(9'b001001001, 96'hF1);
        @(negedge clk);
        chk("stall_hit_ready", o_ring_ready, 1);
        tick();
        drive_ring(9'o007, 96'hF2);
        @(negedge clk);
        chk("stall_hit_ejected", o_local_valid, 1);
        chk("stall_nonhit_ready0", o_ring_ready, 0);
        tick();
        @(negedge clk);
        chk("stall_nonhit_ready1", o_ring_ready, 0);
        tick();
        i_ring_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", o_ring_ready, 1);
        tick();
        i_ring_valid = 1'b0;
        repeat (3) tick();

        // Reset with output valid and 3 packets buffered: all dropped
        i_ring_ready = 1'b0;
        drive_ring(9'o003, 96'h99);
        tick();
        i_ring_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_inj_valid = 1'b1; i_inj_gcid = 9'o003; i_inj_data = 96'h90 + 96'(j);
            tick();
        end
        i_inj_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", o_ring_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ring_valid", o_ring_valid, 0);
        chk("async_rst_local_valid", o_local_valid, 0);
        chk("async_rst_ring_data", o_ring_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        i_ring_ready = 1'b1;
        tick();
        chk("post_rst_inj_ready", o_inj_ready, 1);
        exp_ring_q.push_back({9'o002, 96'h77});
        drive_ring(9'o002, 96'h77);
        @(negedge clk);
        chk("post_rst_ring_pri", o_ring_ready, 1);
        tick();
        i_ring_valid = 1'b0;
        repeat (6) tick();

        for (int t = 0; t < 50 && (exp_ring_q.size() + exp_loc_q.size()) > 0; t++) tick();
        chk("ring_q_drained", exp_ring_q.size(), 0);
        chk("local_q_drained", exp_loc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
